// File: rtl/fir_band_sequencer.sv
// Multi-band FIR sequencer. Each accepted sample is written into a circular
// history buffer, then BANDS dot products of TAPS taps each are computed
// serially (one tap per cycle) against an external combinational coefficient
// ROM. Samples, coefficients and results are sign-magnitude Q0.9.
//
// Ports:
//   clk_slow          - clock, all state updates on its rising edge
//   rst               - synchronous active-high reset
//   in_data/in_valid  - input sample stream; in_ready high only while idle
//   coef_band/idx     - ROM address, zero outside the accumulate phase
//   coef_data         - ROM data for the current address (same cycle)
//   out_data/out_band - band result and its index, held until out_ready
//   out_valid         - result valid
//   busy              - high whenever not idle
module fir_band_sequencer #(
  parameter int unsigned TAPS  = 30,
  parameter int unsigned BANDS = 4
) (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic [9:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] coef_band,
  output logic [4:0] coef_idx,
  input  logic [9:0] coef_data,
  output logic [9:0] out_data,
  output logic [1:0] out_band,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned PtrW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e state_q, state_d;

  logic [9:0]      samples_q [TAPS];
  logic            samp_we;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] newest_q, newest_d;
  logic [PtrW-1:0] tap_q, tap_d;
  logic [1:0]      band_q, band_d;
  logic [23:0]     acc_q, acc_d;
  logic [9:0]      out_data_q, out_data_d;
  logic [1:0]      out_band_q, out_band_d;
  logic            out_valid_q, out_valid_d;

  logic            last_tap;
  logic            last_band;
  logic [PtrW-1:0] rd_idx;
  logic [9:0]      sample;
  logic [17:0]     prod_mag;
  logic [23:0]     term;
  logic [23:0]     acc_sum;
  logic [23:0]     acc_abs;
  logic [23:0]     mag_full;
  logic [8:0]      res_mag;
  logic            res_sign;

  assign last_tap  = (tap_q == PtrW'(TAPS - 1));
  assign last_band = (band_q == 2'(BANDS - 1));

  // Tap k reads the sample k steps older than the newest, wrapping mod TAPS.
  assign rd_idx = (newest_q >= tap_q) ? (newest_q - tap_q)
                                      : (newest_q + PtrW'(TAPS) - tap_q);
  assign sample = samples_q[rd_idx];

  // Zero magnitudes give a zero product, so -0 needs no special handling.
  assign prod_mag = 18'(sample[8:0]) * 18'(coef_data[8:0]);
  assign term     = (sample[9] ^ coef_data[9]) ? -24'(prod_mag) : 24'(prod_mag);
  assign acc_sum  = acc_q + term;

  // Result: |acc| >> 9 saturated to 9 bits; never emit -0.
  assign acc_abs  = acc_sum[23] ? -acc_sum : acc_sum;
  assign mag_full = acc_abs >> 9;
  assign res_mag  = (mag_full > 24'd511) ? 9'h1ff : mag_full[8:0];
  assign res_sign = acc_sum[23] && (res_mag != 9'd0);

  // State register
  always_ff @(posedge clk_slow) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StCalc;
      StCalc:  if (last_tap) state_d = StOut;
      StOut:   if (out_ready) state_d = last_band ? StIdle : StCalc;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    coef_band = 2'd0;
    coef_idx  = 5'd0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StCalc: begin
        coef_band = band_q;
        coef_idx  = 5'(tap_q);
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    samp_we     = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    newest_d    = newest_q;
    tap_d       = tap_q;
    band_d      = band_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_band_d  = out_band_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          samp_we  = 1'b1;
          newest_d = wr_ptr_q;
          wr_ptr_d = (wr_ptr_q == PtrW'(TAPS - 1)) ? '0 : wr_ptr_q + PtrW'(1);
          acc_d    = '0;
          band_d   = 2'd0;
          tap_d    = '0;
        end
      end
      StCalc: begin
        acc_d = acc_sum;
        tap_d = tap_q + PtrW'(1);
        if (last_tap) begin
          tap_d       = '0;
          out_data_d  = {res_sign, res_mag};
          out_band_d  = band_q;
          out_valid_d = 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!last_band) begin
            band_d = band_q + 2'd1;
            acc_d  = '0;
            tap_d  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_slow) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) samples_q[i] <= '0;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      tap_q       <= '0;
      band_q      <= 2'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_band_q  <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      if (samp_we) samples_q[wr_ptr_q] <= in_data;
      wr_ptr_q    <= wr_ptr_d;
      newest_q    <= newest_d;
      tap_q       <= tap_d;
      band_q      <= band_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_band_q  <= out_band_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_band  = out_band_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_band_sequencer.sv
module tb_fir_band_sequencer;

  localparam int TAPS  = 30;
  localparam int BANDS = 4;

  logic       clk_slow = 1'b0;
  logic       rst;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] coef_band;
  logic [4:0] coef_idx;
  logic [9:0] coef_data;
  logic [9:0] out_data;
  logic [1:0] out_band;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  fir_band_sequencer #(.TAPS(TAPS), .BANDS(BANDS)) dut (
    .clk_slow  (clk_slow),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_band (coef_band),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_band  (out_band),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk_slow = ~clk_slow;

  // Coefficient ROM model (combinational)
  logic [9:0] rom [4][32];
  assign coef_data = rom[coef_band][coef_idx];

  typedef struct {
    logic [9:0] data;
    logic [1:0] band;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] hist[$];   // hist[0] newest, hist[TAPS-1] oldest
  int         tests = 0;
  int         fails = 0;
  int         ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sm_val(input logic [9:0] v);
    return v[9] ? -int'(v[8:0]) : int'(v[8:0]);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    repeat (TAPS) hist.push_back(10'd0);
  endtask

  // Accepted sample: update history, queue one expected result per band.
  task automatic model_accept(input logic [9:0] d);
    int   acc;
    int   mag;
    exp_t e;
    hist.push_front(d);
    void'(hist.pop_back());
    for (int b = 0; b < BANDS; b++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += sm_val(hist[k]) * sm_val(rom[b][k]);
      mag = ((acc < 0) ? -acc : acc) / 512;
      if (mag > 511) mag = 511;
      e.data = {(acc < 0 && mag != 0), 9'(mag)};
      e.band = 2'(b);
      exp_q.push_back(e);
    end
  endtask

  task automatic rom_fill(input logic [9:0] tap0, input logic [9:0] rest);
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 32; k++)
        rom[b][k] = (k >= TAPS) ? 10'd0 : ((k == 0) ? tap0 : rest);
  endtask

  task automatic rom_random();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 32; k++)
        rom[b][k] = (k >= TAPS) ? 10'd0 : {1'($urandom), 9'($urandom_range(1, 511))};
  endtask

  // Present a sample and wait for it to be accepted.
  task automatic send(input logic [9:0] d);
    int n = 0;
    @(negedge clk_slow);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(negedge clk_slow);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk_slow);
      model_accept(d);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk_slow);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk_slow);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expected result per output handshake.
  exp_t mon_e;
  always @(negedge clk_slow) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_band", 32'(out_band), 32'(mon_e.band));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap_d;
    logic [1:0] cap_b;
    int         n;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    rom_fill(10'd0, 10'd0);
    model_reset();
    repeat (2) @(posedge clk_slow);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_coef_idx", 32'(coef_idx), 32'd0);

    // Impulse, with band-0 latency
    rom_fill(10'd64, 10'd0);
    ready_mode = 0;
    send(10'd256);
    n = 1;
    @(negedge clk_slow);
    while (!out_valid && n < 100) begin
      @(negedge clk_slow);
      n++;
    end
    check("latency_band0", 32'(n), 32'(TAPS + 1));
    check("impulse_value", 32'(out_data), 32'b0000100000);
    wait_drain();

    // Sign handling and -0 input
    rom_fill(10'b1001000000, 10'd0);
    send(10'd256);
    wait_drain();
    send(10'b1000000000);
    wait_drain();

    // Saturation and buffer wrap
    rom_fill(10'd511, 10'd511);
    for (int i = 0; i < 31; i++) send(10'd511);
    wait_drain();

    // Backpressure in OUT; in_valid pulses must be ignored
    rom_random();
    @(negedge clk_slow);
    ready_mode = 2;
    send(10'($urandom));
    n = 0;
    @(negedge clk_slow);
    while (!out_valid && n < 100) begin
      @(negedge clk_slow);
      n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    cap_d = out_data;
    cap_b = out_band;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_slow);
      #2;
      in_valid = 1'b1;
      in_data  = 10'($urandom);
      @(negedge clk_slow);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_data_hold", 32'(out_data), 32'(cap_d));
      check("bp_band_hold", 32'(out_band), 32'(cap_b));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_coef_band", 32'(coef_band), 32'd0);
    end
    @(posedge clk_slow);
    #2 in_valid = 1'b0;
    @(negedge clk_slow);
    ready_mode = 0;
    wait_drain();

    // Reset mid-CALC with in_valid also asserted
    send(10'($urandom));
    repeat (10) @(negedge clk_slow);
    @(posedge clk_slow);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd300;
    @(posedge clk_slow);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_band", 32'(out_band), 32'd0);
    model_reset();
    send(10'($urandom));
    wait_drain();

    // Randomized traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        wait_drain();
        rom_random();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_slow);
      send(10'($urandom));
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
